// File: rtl/inst_fetch_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_if
// Instruction-memory fetch bus: one word request/grant followed by a read
// response.
//   imem_req    : fetch request (master -> memory)
//   imem_addr   : word-aligned fetch address (master -> memory)
//   imem_gnt    : memory accepts the request this cycle (memory -> master)
//   imem_rvalid : read data valid (memory -> master)
//   imem_rdata  : instruction word (memory -> master)
//   imem_err    : bus error, qualified by imem_rvalid (memory -> master)
// -----------------------------------------------------------------------------
interface inst_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        imem_err;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata,
        input  imem_err
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata,
        output imem_err
    );
endinterface

// File: rtl/inst_fetch.sv
// -----------------------------------------------------------------------------
// inst_fetch
// RV32 instruction fetch unit. Holds the architectural PC, issues a single
// outstanding word fetch, presents the instruction to decode and waits for the
// write-back stage to commit the next PC before fetching again.
// Ports:
//   i_clk, i_rst_n  : clock, asynchronous active-low reset
//   i_pc_new        : next PC from write-back
//   i_pc_we         : write-back commit strobe
//   imem            : fetch bus (master side)
//   o_inst_valid    : o_inst / o_inst_pc valid
//   o_inst          : fetched instruction word
//   o_inst_pc       : PC of o_inst
//   o_fault         : sticky fetch fault
//   o_fault_cause   : 01 misaligned target, 10 bus error, 00 none
//   o_fetch_cnt     : number of commits accepted (wraps)
// -----------------------------------------------------------------------------
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [31:0]       i_pc_new,
    input  logic              i_pc_we,
    inst_fetch_if.master      imem,
    output logic              o_inst_valid,
    output logic [31:0]       o_inst,
    output logic [31:0]       o_inst_pc,
    output logic              o_fault,
    output logic [1:0]        o_fault_cause,
    output logic [31:0]       o_fetch_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3,
        S_FAULT = 3'd4
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_ALIGN = 2'b01;
    localparam logic [1:0] CAUSE_BUS   = 2'b10;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_inst;
    logic [31:0] r_inst_pc;
    logic [31:0] r_fetch_cnt;
    logic        r_req;
    logic        r_inst_valid;
    logic        r_fault;
    logic [1:0]  r_fault_cause;

    // State and all visible flags live in one registered process so that no
    // input reaches an output combinationally. Each flag is set on entry to
    // its state and cleared on exit.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_inst        <= 32'h0;
            r_inst_pc     <= 32'h0;
            r_fetch_cnt   <= 32'h0;
            r_req         <= 1'b0;
            r_inst_valid  <= 1'b0;
            r_fault       <= 1'b0;
            r_fault_cause <= CAUSE_NONE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_state <= S_REQ;
                    r_req   <= 1'b1;
                end
                S_REQ: begin
                    if (imem.imem_gnt) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (imem.imem_rvalid) begin
                        if (imem.imem_err) begin
                            r_state       <= S_FAULT;
                            r_fault       <= 1'b1;
                            r_fault_cause <= CAUSE_BUS;
                        end else begin
                            r_state      <= S_VALID;
                            r_inst_valid <= 1'b1;
                            r_inst       <= imem.imem_rdata;
                            r_inst_pc    <= r_pc;
                        end
                    end
                end
                S_VALID: begin
                    if (i_pc_we) begin
                        // A misaligned commit still counts as committed; the
                        // PC keeps the address of the last good fetch.
                        r_fetch_cnt  <= r_fetch_cnt + 32'd1;
                        r_inst_valid <= 1'b0;
                        if (i_pc_new[1:0] == 2'b00) begin
                            r_state <= S_REQ;
                            r_req   <= 1'b1;
                            r_pc    <= i_pc_new;
                        end else begin
                            r_state       <= S_FAULT;
                            r_fault       <= 1'b1;
                            r_fault_cause <= CAUSE_ALIGN;
                        end
                    end
                end
                S_FAULT: begin
                    // Terminal until reset.
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_req        <= 1'b0;
                    r_inst_valid <= 1'b0;
                    r_fault      <= 1'b0;
                end
            endcase
        end
    end

    assign imem.imem_req  = r_req;
    assign imem.imem_addr = r_pc;
    assign o_inst_valid   = r_inst_valid;
    assign o_inst         = r_inst;
    assign o_inst_pc      = r_inst_pc;
    assign o_fault        = r_fault;
    assign o_fault_cause  = r_fault_cause;
    assign o_fetch_cnt    = r_fetch_cnt;

endmodule

// File: tb/tb_inst_fetch.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch
// Directed bench for inst_fetch. Inputs change and outputs are sampled on the
// falling clock edge; the DUT acts on the rising edge.
// -----------------------------------------------------------------------------
module tb_inst_fetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc_new;
    logic        pc_we;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] fetch_cnt;

    int n_chk;
    int n_fail;
    int n_req;

    inst_fetch_if imem ();

    inst_fetch #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_pc_new      (pc_new),
        .i_pc_we       (pc_we),
        .imem          (imem),
        .o_inst_valid  (inst_valid),
        .o_inst        (inst),
        .o_inst_pc     (inst_pc),
        .o_fault       (fault),
        .o_fault_cause (fault_cause),
        .o_fetch_cnt   (fetch_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Granted requests, counted while out of reset.
    always @(posedge clk) begin
        if (rst_n && imem.imem_req && imem.imem_gnt) n_req <= n_req + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    typedef struct {
        int          gw;        // gnt wait cycles
        int          rw;        // rvalid wait cycles
        logic [31:0] rdata;
        logic [31:0] exp_addr;
        logic [31:0] pc_nxt;
        logic [31:0] exp_cnt;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_req"},   32'(imem.imem_req), 32'd0);
        chk({tag, "_addr"},  imem.imem_addr, 32'h0000_0100);
        chk({tag, "_valid"}, 32'(inst_valid), 32'd0);
        chk({tag, "_fault"}, 32'(fault), 32'd0);
        chk({tag, "_cause"}, 32'(fault_cause), 32'd0);
        chk({tag, "_inst"},  inst, 32'd0);
        chk({tag, "_ipc"},   inst_pc, 32'd0);
        chk({tag, "_cnt"},   fetch_cnt, 32'd0);
    endtask

    // Entered on a falling edge; waits (bounded) for a request, then runs the
    // grant and response phases. Returns on the falling edge after the
    // response was sampled.
    task automatic fetch(input int gw, input int rw, input logic [31:0] rdata,
                         input logic err, input logic [31:0] exp_addr);
        int k;
        k = 0;
        while (imem.imem_req !== 1'b1 && k < 16) begin
            step();
            k++;
        end
        chk("req_seen", 32'(imem.imem_req), 32'd1);
        chk("req_addr", imem.imem_addr, exp_addr);
        for (int i = 0; i < gw; i++) begin
            step();
            chk("req_hold", 32'(imem.imem_req), 32'd1);
            chk("addr_hold", imem.imem_addr, exp_addr);
        end
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        chk("req_drop", 32'(imem.imem_req), 32'd0);
        for (int i = 0; i < rw; i++) step();
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = rdata;
        imem.imem_err    = err;
        step();
        imem.imem_rvalid = 1'b0;
        imem.imem_err    = 1'b0;
        imem.imem_rdata  = 32'h0;
    endtask

    task automatic commit(input logic [31:0] pcn);
        pc_we  = 1'b1;
        pc_new = pcn;
        step();
        pc_we  = 1'b0;
        pc_new = 32'h0;
    endtask

    initial begin
        int bad;
        n_chk  = 0;
        n_fail = 0;
        n_req  = 0;
        rst_n  = 1'b0;
        pc_we  = 1'b0;
        pc_new = 32'h0;
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        imem.imem_err    = 1'b0;

        vecs[0] = '{0, 0, 32'h0000_0013, 32'h0000_0100, 32'h0000_0104, 32'd1};
        vecs[1] = '{1, 0, 32'h00a0_0093, 32'h0000_0104, 32'h0000_0108, 32'd2};
        vecs[2] = '{0, 2, 32'h0010_8113, 32'h0000_0108, 32'h0000_010c, 32'd3};
        vecs[3] = '{3, 1, 32'h0020_81b3, 32'h0000_010c, 32'h0000_0110, 32'd4};
        vecs[4] = '{2, 3, 32'h4031_0233, 32'h0000_0110, 32'h0000_0114, 32'd5};
        vecs[5] = '{0, 1, 32'h0000_a283, 32'h0000_0114, 32'h0000_0118, 32'd6};
        vecs[6] = '{1, 2, 32'h0051_2023, 32'h0000_0118, 32'h0000_011c, 32'd7};
        vecs[7] = '{3, 0, 32'hfe00_0ee3, 32'h0000_011c, 32'h0000_0120, 32'd8};
        vecs[8] = '{2, 2, 32'h00c0_00ef, 32'h0000_0120, 32'h0000_0124, 32'd9};
        vecs[9] = '{1, 3, 32'h0000_8067, 32'h0000_0124, 32'h0000_2000, 32'd10};

        // Reset and boot
        repeat (2) step();
        chk_reset("rst0");
        rst_n = 1'b1;
        #1;
        chk("boot_idle_req", 32'(imem.imem_req), 32'd0);
        step();
        chk("boot_req", 32'(imem.imem_req), 32'd1);
        chk("boot_addr", imem.imem_addr, 32'h0000_0100);

        // Sequential loop ending in a branch to 0x2000
        for (int i = 0; i < 10; i++) begin
            fetch(vecs[i].gw, vecs[i].rw, vecs[i].rdata, 1'b0, vecs[i].exp_addr);
            chk("vld", 32'(inst_valid), 32'd1);
            chk("inst", inst, vecs[i].rdata);
            chk("inst_pc", inst_pc, vecs[i].exp_addr);
            chk("no_req_in_valid", 32'(imem.imem_req), 32'd0);
            commit(vecs[i].pc_nxt);
            chk("cnt", fetch_cnt, vecs[i].exp_cnt);
            chk("next_req", 32'(imem.imem_req), 32'd1);
            chk("next_addr", imem.imem_addr, vecs[i].pc_nxt);
            chk("vld_drop", 32'(inst_valid), 32'd0);
        end
        chk("one_req_per_inst", 32'(n_req), 32'd10);

        // Spurious rvalid and pc_we while in REQ are ignored
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'hdead_beef;
        pc_we  = 1'b1;
        pc_new = 32'h0000_3000;
        step();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        pc_we  = 1'b0;
        pc_new = 32'h0;
        chk("spur_inst", inst, 32'h0000_8067);
        chk("spur_ipc", inst_pc, 32'h0000_0124);
        chk("spur_req", 32'(imem.imem_req), 32'd1);
        chk("spur_addr", imem.imem_addr, 32'h0000_2000);
        chk("spur_cnt", fetch_cnt, 32'd10);

        fetch(0, 1, 32'h0000_006f, 1'b0, 32'h0000_2000);
        chk("br_inst", inst, 32'h0000_006f);
        chk("br_ipc", inst_pc, 32'h0000_2000);

        // Misaligned target
        commit(32'h0000_2002);
        chk("mis_fault", 32'(fault), 32'd1);
        chk("mis_cause", 32'(fault_cause), 32'd1);
        chk("mis_req", 32'(imem.imem_req), 32'd0);
        chk("mis_cnt", fetch_cnt, 32'd11);
        chk("mis_pc", imem.imem_addr, 32'h0000_2000);
        chk("mis_valid", 32'(inst_valid), 32'd0);
        bad = 0;
        imem.imem_gnt    = 1'b1;
        imem.imem_rvalid = 1'b1;
        pc_we  = 1'b1;
        pc_new = 32'h0000_3000;
        for (int i = 0; i < 6; i++) begin
            step();
            if (imem.imem_req !== 1'b0 || fault !== 1'b1 || inst_valid !== 1'b0) bad++;
        end
        imem.imem_gnt    = 1'b0;
        imem.imem_rvalid = 1'b0;
        pc_we  = 1'b0;
        pc_new = 32'h0;
        chk("fault_terminal", 32'(bad), 32'd0);
        chk("fault_cnt_frozen", fetch_cnt, 32'd11);
        chk("fault_cause_hold", 32'(fault_cause), 32'd1);

        // Bus error
        rst_n = 1'b0;
        step();
        chk_reset("rst1");
        rst_n = 1'b1;
        fetch(1, 1, 32'h1234_5678, 1'b1, 32'h0000_0100);
        chk("berr_fault", 32'(fault), 32'd1);
        chk("berr_cause", 32'(fault_cause), 32'd2);
        chk("berr_inst", inst, 32'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (inst_valid !== 1'b0 || imem.imem_req !== 1'b0) bad++;
            step();
        end
        chk("berr_no_valid", 32'(bad), 32'd0);
        rst_n = 1'b0;
        step();
        chk_reset("rst2");

        // Reset mid-WAIT, late rvalid after release
        rst_n = 1'b1;
        step();
        chk("mw_req", 32'(imem.imem_req), 32'd1);
        imem.imem_gnt = 1'b1;
        step();
        imem.imem_gnt = 1'b0;
        chk("mw_in_wait", 32'(imem.imem_req), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mw_req_low", 32'(imem.imem_req), 32'd0);
        chk("mw_valid_low", 32'(inst_valid), 32'd0);
        step();
        rst_n = 1'b1;
        imem.imem_rvalid = 1'b1;
        imem.imem_rdata  = 32'h0bad_0bad;
        step();
        imem.imem_rvalid = 1'b0;
        imem.imem_rdata  = 32'h0;
        chk("late_rv_inst", inst, 32'd0);
        chk("late_rv_valid", 32'(inst_valid), 32'd0);
        chk("late_rv_req", 32'(imem.imem_req), 32'd1);

        // Async reset in REQ drops the request without a clock edge
        #2 rst_n = 1'b0;
        #1;
        chk("async_req_clear", 32'(imem.imem_req), 32'd0);
        step();
        rst_n = 1'b1;

        // Counter wrap
        fetch(0, 0, 32'h0000_0013, 1'b0, 32'h0000_0100);
        chk("wrap_valid", 32'(inst_valid), 32'd1);
        force dut.r_fetch_cnt = 32'hffff_ffff;
        #1;
        release dut.r_fetch_cnt;
        commit(32'h0000_0104);
        chk("wrap_cnt", fetch_cnt, 32'd0);
        chk("wrap_fault", 32'(fault), 32'd0);
        chk("wrap_req", 32'(imem.imem_req), 32'd1);
        chk("wrap_addr", imem.imem_addr, 32'h0000_0104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
